// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, argmax encoding and unpool state type
package cnn_pkg;

    localparam int DATA_W       = 32;
    localparam int CHANNELS     = 16;
    localparam int POOL_IN_DIM  = 14;
    localparam int POOL_OUT_DIM = 28;

    // Argmax position inside a 2x2 window: bit1 = dy, bit0 = dx.
    typedef enum logic [1:0] {
        POS_TL = 2'd0,
        POS_TR = 2'd1,
        POS_BL = 2'd2,
        POS_BR = 2'd3
    } pool_pos_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TOP_ACCEPT = 3'd1,
        ST_TOP_EMIT   = 3'd2,
        ST_BOT_EMIT   = 3'd3,
        ST_DONE       = 3'd4
    } unpool_state_t;

    // A single-channel build still needs a one-bit channel field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxunpool2d_stream_if.sv
// rtl/maxunpool2d_stream_if.sv - pooled-input and unpooled-output stream bundle
interface maxunpool2d_stream_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic [1:0]               in_idx;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [CH_W-1:0]          out_ch;
    logic [4:0]               out_row;
    logic [4:0]               out_col;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_row, out_col, out_last
    );
endinterface

// File: rtl/unpool_line_buffer.sv
// rtl/unpool_line_buffer.sv - per-column store of {value, idx} for the bottom output row
module unpool_line_buffer #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 34,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately not reset; every entry is written before it is read.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxunpool2d_stream.sv
// rtl/maxunpool2d_stream.sv - 2x2/stride-2 max-unpool: scatters pooled values to argmax positions
module maxunpool2d_stream #(
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int CHANNELS = cnn_pkg::CHANNELS,
    parameter int IN_DIM   = cnn_pkg::POOL_IN_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    maxunpool2d_stream_if.slave   bus
);
    import cnn_pkg::*;

    localparam int RC_W = $clog2(IN_DIM);
    localparam int CH_W = ch_width(CHANNELS);
    localparam logic [RC_W-1:0] LAST_RC = RC_W'(IN_DIM - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    unpool_state_t            state;
    logic [CH_W-1:0]          ch;
    logic [RC_W-1:0]          r;
    logic [RC_W-1:0]          c;
    logic [RC_W-1:0]          c_nxt;
    logic                     dx;
    logic signed [DATA_W-1:0] hold_val;
    logic [1:0]               hold_idx;

    logic                     in_ready_r;
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] out_data_r;
    logic [CH_W-1:0]          out_ch_r;
    logic [4:0]               out_row_r;
    logic [4:0]               out_col_r;
    logic                     out_last_r;

    logic                     in_xfer;
    logic                     out_xfer;
    logic [RC_W-1:0]          rd_addr;
    logic [DATA_W+1:0]        wr_word;
    logic [DATA_W+1:0]        rd_word;
    logic signed [DATA_W-1:0] rd_val;
    logic [1:0]               rd_idx;

    assign in_xfer  = bus.in_valid && in_ready_r;
    assign out_xfer = out_valid_r && bus.out_ready;
    assign c_nxt    = c + RC_W'(1);
    assign wr_word  = {bus.in_data, bus.in_idx};
    assign rd_val   = rd_word[DATA_W+1:2];
    assign rd_idx   = rd_word[1:0];

    // The buffer is read for the beat that follows the current one, so the output stays registered.
    always_comb begin
        rd_addr = '0;
        if (state == ST_BOT_EMIT) begin
            if (!dx) begin
                rd_addr = c;
            end else if (c != LAST_RC) begin
                rd_addr = c_nxt;
            end
        end
    end

    unpool_line_buffer #(
        .DEPTH (IN_DIM),
        .WIDTH (DATA_W + 2)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (in_xfer),
        .wr_addr (c),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ch          <= '0;
            r           <= '0;
            c           <= '0;
            dx          <= 1'b0;
            hold_val    <= '0;
            hold_idx    <= '0;
            done        <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_row_r   <= '0;
            out_col_r   <= '0;
            out_last_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ch         <= '0;
                        r          <= '0;
                        c          <= '0;
                        dx         <= 1'b0;
                        in_ready_r <= 1'b1;
                        state      <= ST_TOP_ACCEPT;
                    end
                end

                ST_TOP_ACCEPT: begin
                    if (in_xfer) begin
                        hold_val    <= bus.in_data;
                        hold_idx    <= bus.in_idx;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_ch_r    <= ch;
                        out_row_r   <= 5'({r, 1'b0});
                        out_col_r   <= 5'({c, 1'b0});
                        out_data_r  <= (bus.in_idx == POS_TL) ? bus.in_data : '0;
                        out_last_r  <= 1'b0;
                        dx          <= 1'b0;
                        state       <= ST_TOP_EMIT;
                    end
                end

                ST_TOP_EMIT: begin
                    if (out_xfer) begin
                        if (!dx) begin
                            dx         <= 1'b1;
                            out_col_r  <= 5'({c, 1'b1});
                            out_data_r <= (hold_idx == POS_TR) ? hold_val : '0;
                        end else if (c != LAST_RC) begin
                            c           <= c_nxt;
                            dx          <= 1'b0;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state       <= ST_TOP_ACCEPT;
                        end else begin
                            c          <= '0;
                            dx         <= 1'b0;
                            out_row_r  <= 5'({r, 1'b1});
                            out_col_r  <= '0;
                            out_data_r <= (rd_idx == POS_BL) ? rd_val : '0;
                            state      <= ST_BOT_EMIT;
                        end
                    end
                end

                ST_BOT_EMIT: begin
                    if (out_xfer) begin
                        if (!dx) begin
                            dx         <= 1'b1;
                            out_col_r  <= 5'({c, 1'b1});
                            out_data_r <= (rd_idx == POS_BR) ? rd_val : '0;
                            out_last_r <= (r == LAST_RC) && (c == LAST_RC);
                        end else if (c != LAST_RC) begin
                            c          <= c_nxt;
                            dx         <= 1'b0;
                            out_col_r  <= 5'({c_nxt, 1'b0});
                            out_data_r <= (rd_idx == POS_BL) ? rd_val : '0;
                            out_last_r <= 1'b0;
                        end else begin
                            c           <= '0;
                            dx          <= 1'b0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            if (r != LAST_RC) begin
                                r          <= r + RC_W'(1);
                                in_ready_r <= 1'b1;
                                state      <= ST_TOP_ACCEPT;
                            end else if (ch != LAST_CH) begin
                                ch         <= ch + CH_W'(1);
                                r          <= '0;
                                in_ready_r <= 1'b1;
                                state      <= ST_TOP_ACCEPT;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state       <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_row   = out_row_r;
    assign bus.out_col   = out_col_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_maxunpool2d_stream.sv
// tb/tb_maxunpool2d_stream.sv - scoreboard bench for maxunpool2d_stream (1- and 16-channel builds)
module tb_maxunpool2d_stream;

    localparam int DW  = 32;
    localparam int DIM = 14;

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic [3:0]           ch;
        logic [4:0]           row;
        logic [4:0]           col;
        logic                 last;
        logic                 fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                 sel16 = 1'b0;
    logic                 start_s = 1'b0;
    logic                 in_valid_s = 1'b0;
    logic signed [DW-1:0] in_data_s = '0;
    logic [1:0]           in_idx_s = '0;
    logic                 out_ready_s = 1'b1;
    logic                 bp_en = 1'b0;
    logic                 done1, done16;

    maxunpool2d_stream_if #(.DATA_W(DW), .CH_W(1)) bus1 ();
    maxunpool2d_stream_if #(.DATA_W(DW), .CH_W(4)) bus16 ();

    assign bus1.in_valid   = in_valid_s & ~sel16;
    assign bus1.in_data    = in_data_s;
    assign bus1.in_idx     = in_idx_s;
    assign bus1.out_ready  = out_ready_s;
    assign bus16.in_valid  = in_valid_s & sel16;
    assign bus16.in_data   = in_data_s;
    assign bus16.in_idx    = in_idx_s;
    assign bus16.out_ready = out_ready_s;

    maxunpool2d_stream #(.DATA_W(DW), .CHANNELS(1), .IN_DIM(DIM)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start_s & ~sel16),
        .done  (done1),
        .bus   (bus1)
    );

    maxunpool2d_stream #(.DATA_W(DW), .CHANNELS(16), .IN_DIM(DIM)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start_s & sel16),
        .done  (done16),
        .bus   (bus16)
    );

    logic                 o_valid, o_in_ready, o_last, o_done;
    logic signed [DW-1:0] o_data;
    logic [3:0]           o_ch;
    logic [4:0]           o_row, o_col;

    assign o_valid    = sel16 ? bus16.out_valid : bus1.out_valid;
    assign o_in_ready = sel16 ? bus16.in_ready  : bus1.in_ready;
    assign o_data     = sel16 ? bus16.out_data  : bus1.out_data;
    assign o_ch       = sel16 ? bus16.out_ch    : {3'b000, bus1.out_ch};
    assign o_row      = sel16 ? bus16.out_row   : bus1.out_row;
    assign o_col      = sel16 ? bus16.out_col   : bus1.out_col;
    assign o_last     = sel16 ? bus16.out_last  : bus1.out_last;
    assign o_done     = sel16 ? done16          : done1;

    logic signed [DW-1:0] vmem [16][DIM][DIM];
    logic [1:0]           imem [16][DIM][DIM];

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   beats = 0;
    int   done_cnt = 0;
    bit   exp_done = 1'b0;
    bit   abort = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_top(input int ch, input int r, input int c);
        exp_t e;
        for (int dx = 0; dx < 2; dx++) begin
            e.data = (imem[ch][r][c] == 2'(dx)) ? vmem[ch][r][c] : '0;
            e.ch   = 4'(ch);
            e.row  = 5'(2 * r);
            e.col  = 5'(2 * c + dx);
            e.last = 1'b0;
            e.fin  = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic push_bottom(input int ch, input int r, input int nch);
        exp_t e;
        for (int c = 0; c < DIM; c++) begin
            for (int dx = 0; dx < 2; dx++) begin
                e.data = (imem[ch][r][c] == 2'(2 + dx)) ? vmem[ch][r][c] : '0;
                e.ch   = 4'(ch);
                e.row  = 5'(2 * r + 1);
                e.col  = 5'(2 * c + dx);
                e.last = (r == DIM - 1) && (c == DIM - 1) && (dx == 1);
                e.fin  = e.last && (ch == nch - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_done || o_done) check_eq("done_pulse", 64'(o_done), 64'(exp_done));
            if (o_done) done_cnt++;
            exp_done = 1'b0;
            if (o_valid) begin
                check_eq("in_ready_while_emitting", 64'(o_in_ready), 64'd0);
                if (q.size() == 0) begin
                    check_eq("unexpected_beat", 64'(o_valid), 64'd0);
                end else begin
                    e = q[0];
                    check_eq("out_data", 64'(o_data), 64'(e.data));
                    check_eq("out_ch",   64'(o_ch),   64'(e.ch));
                    check_eq("out_row",  64'(o_row),  64'(e.row));
                    check_eq("out_col",  64'(o_col),  64'(e.col));
                    check_eq("out_last", 64'(o_last), 64'(e.last));
                    if (out_ready_s) begin
                        void'(q.pop_front());
                        beats++;
                        if (e.fin) exp_done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
    endtask

    task automatic drive(input int nch, input bit gaps, input bit noise);
        int  g;
        bit  got;
        for (int ch = 0; ch < nch; ch++) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (abort) return;
                    if (noise && c == 7 && (r % 4) == 1) pulse_start();
                    g = gaps ? $urandom_range(0, 2) : 0;
                    if (g > 0) begin
                        in_valid_s = 1'b0;
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    in_valid_s = 1'b1;
                    in_data_s  = vmem[ch][r][c];
                    in_idx_s   = imem[ch][r][c];
                    got = 1'b0;
                    for (int k = 0; k < 1000 && !got; k++) begin
                        @(negedge clk);
                        if (abort) return;
                        got = o_in_ready;
                    end
                    if (!got) begin
                        check_eq("input_accept_timeout", 64'd0, 64'd1);
                        abort = 1'b1;
                        return;
                    end
                    push_top(ch, r, c);
                    if (c == DIM - 1) push_bottom(ch, r, nch);
                    @(posedge clk); #1;
                end
            end
        end
        in_valid_s = 1'b0;
    endtask

    task automatic run(input bit use16, input int nch, input bit gaps, input bit bp,
                       input bit noise, input int abort_at);
        int d0;
        bit fin;
        sel16 = use16;
        bp_en = bp;
        abort = 1'b0;
        beats = 0;
        q.delete();
        d0 = done_cnt;
        pulse_start();
        fork
            drive(nch, gaps, noise);
            if (abort_at > 0) begin
                for (int k = 0; k < 20000 && beats < abort_at; k++) @(negedge clk);
                @(posedge clk); #1 reset = 1'b1;
                abort = 1'b1;
                q.delete();
                @(negedge clk);
                check_eq("reset_out_valid", 64'(o_valid), 64'd0);
                check_eq("reset_in_ready", 64'(o_in_ready), 64'd0);
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        in_valid_s = 1'b0;
        if (abort_at > 0) begin
            repeat (5) @(posedge clk);
            check_eq("reset_no_done", 64'(done_cnt - d0), 64'd0);
        end else begin
            fin = 1'b0;
            for (int k = 0; k < 40000 && !fin; k++) begin
                @(posedge clk);
                fin = (q.size() == 0) && (done_cnt != d0);
            end
            repeat (3) @(posedge clk);
            check_eq("run_beats", 64'(beats), 64'(nch * 4 * DIM * DIM));
            check_eq("run_done_count", 64'(done_cnt - d0), 64'd1);
        end
        bp_en = 1'b0;
        #1;
    endtask

    task automatic fill_random(input int nch);
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    vmem[ch][r][c] = $signed($urandom);
                    imem[ch][r][c] = 2'($urandom_range(0, 3));
                end
    endtask

    initial begin
        fork
            monitor();
            forever begin
                @(posedge clk); #1;
                out_ready_s = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel16 = s[0];
            @(negedge clk);
            check_eq("rst_done",      64'(o_done),     64'd0);
            check_eq("rst_in_ready",  64'(o_in_ready), 64'd0);
            check_eq("rst_out_valid", 64'(o_valid),    64'd0);
            check_eq("rst_out_last",  64'(o_last),     64'd0);
            check_eq("rst_out_data",  64'(o_data),     64'd0);
        end

        // Ramp, all top-left.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                vmem[0][r][c] = 32'(100 + 14 * r + c);
                imem[0][r][c] = 2'd0;
            end
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 0);

        // Beats after a completed run must wait for the next start.
        in_valid_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("idle_in_ready", 64'(o_in_ready), 64'd0);
        end
        @(posedge clk); #1 in_valid_s = 1'b0;

        // Single -5 window at each argmax position.
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    vmem[0][r][c] = '0;
                    imem[0][r][c] = 2'd0;
                end
            vmem[0][0][0] = -32'sd5;
            imem[0][0][0] = 2'(p);
            run(1'b0, 1, 1'b0, 1'b0, 1'b0, 0);
        end

        // Backpressure with gapped input.
        fill_random(1);
        run(1'b0, 1, 1'b1, 1'b1, 1'b0, 0);

        // Full 16-channel run with stray start pulses.
        fill_random(16);
        run(1'b1, 16, 1'b0, 1'b0, 1'b1, 0);

        // Reset mid-run, then a fresh run from beat 0.
        fill_random(1);
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 300);
        run(1'b0, 1, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
